stage_if: RTL and testbench

Instruction-fetch stage at the front of the pipeline, upstream of decode and the decode/execute register.
- Holds the program counter and issues word requests on an in-order req/gnt/rvalid instruction-memory port.
- Buffers returned instructions with their PCs in a small queue and presents one per cycle to decode.
- Redirects to a branch/jump target on pipeline flush; freezes presentation on pipeline stall.

---
 rtl/stage_if_pkg.sv | 28 ++
 rtl/stage_if_if.sv | 26 ++
 rtl/stage_if_queue.sv | 69 ++++++
 rtl/stage_if.sv | 120 ++++++++++++
 tb/tb_stage_if.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/stage_if_pkg.sv
// Shared constants, FSM encoding and queue entry type for the instruction-fetch stage.
package stage_if_pkg;

   localparam logic [31:0] NOP_INST       = 32'h0000_0013;
   localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;
   localparam logic        RESET_ENABLE   = 1'b0;
   localparam logic        PLFLUSH_ENABLE = 1'b1;
   localparam logic        PC_STOP_ENABLE = 1'b1;

   typedef enum logic [0:0] {
      BOOT  = 1'b0,
      FETCH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & 32'hFFFF_FFFC;
   endfunction

   function automatic logic [31:0] next_pc(input logic [31:0] addr);
      return addr + 32'd4;
   endfunction

endpackage

// File: rtl/stage_if_if.sv
// In-order req/gnt/rvalid instruction-memory port between the fetch stage and memory.
interface stage_if_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/stage_if_queue.sv
// DEPTH-entry FIFO of {pc, inst}; clear empties it on the next edge and beats push/pop.
module stage_if_queue
   import stage_if_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic         clear_i,
   input  fetch_entry_t push_entry_i,
   output fetch_entry_t head_o,
   output logic [CW-1:0] count_o
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   // Next storage, pointer and occupancy values
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d        = wr_ptr_q + PW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   // Queue state registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (rst_i == RESET_ENABLE) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC and credit-limited in-order fetch, flush redirection
// with discard of stale responses, and one-per-cycle presentation to decode.
module stage_if
   import stage_if_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        pipeline_flush_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        pipeline_nop_i,
   stage_if_if.master  imem,
   output logic        valid_do,
   output logic [31:0] inst_do,
   output logic [31:0] pc_do
);

   localparam int             CW      = $clog2(DEPTH) + 1;
   localparam int             CW1     = CW + 1;
   localparam logic [CW1-1:0] DEPTH_W = CW1'(DEPTH);

   fetch_state_e   state_q, state_d;
   logic [31:0]    pc_q, pc_d;
   logic [31:0]    resp_pc_q, resp_pc_d;
   logic [CW-1:0]  outstanding_q, outstanding_d;
   logic [CW-1:0]  discard_q, discard_d;
   logic [CW-1:0]  count;
   logic [CW1-1:0] credit_used;
   logic           flush, stall, valid, req, issue, resp, drop, push, pop;
   fetch_entry_t   head, push_entry;

   assign flush      = (pipeline_flush_i == PLFLUSH_ENABLE);
   assign stall      = (pipeline_nop_i == PC_STOP_ENABLE);
   assign valid      = (count != '0);
   assign push_entry = {resp_pc_q, imem.imem_rdata};

   // FSM state register
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (rst_i == RESET_ENABLE) begin
         state_q <= BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: one BOOT cycle after reset, then FETCH forever
   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = FETCH;
         FETCH:   state_d = FETCH;
         default: state_d = BOOT;
      endcase
   end

   // FSM output: request only while queue plus in-flight words leave a free slot
   always_comb begin
      credit_used = {1'b0, count} + {1'b0, outstanding_q};
      req         = 1'b0;
      case (state_q)
         FETCH:   req = (credit_used < DEPTH_W);
         BOOT:    req = 1'b0;
         default: req = 1'b0;
      endcase
   end

   // Issue/response bookkeeping; a flush redirects and marks every in-flight word stale
   always_comb begin
      issue         = req && imem.imem_gnt;
      resp          = imem.imem_rvalid && (outstanding_q != '0);
      drop          = resp && (discard_q != '0);
      push          = resp && (discard_q == '0) && !flush;
      pop           = valid && !stall && !flush;
      outstanding_d = outstanding_q + CW'(issue) - CW'(resp);
      if (flush) begin
         pc_d      = word_align(redirect_pc_i);
         resp_pc_d = word_align(redirect_pc_i);
         discard_d = outstanding_d;
      end else begin
         pc_d      = issue ? next_pc(pc_q) : pc_q;
         resp_pc_d = push ? next_pc(resp_pc_q) : resp_pc_q;
         discard_d = discard_q - CW'(drop);
      end
   end

   // Fetch datapath registers
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (rst_i == RESET_ENABLE) begin
         pc_q          <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         pc_q          <= pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
      end
   end

   stage_if_queue #(.DEPTH(DEPTH)) u_queue (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .push_i       (push),
      .pop_i        (pop),
      .clear_i      (flush),
      .push_entry_i (push_entry),
      .head_o       (head),
      .count_o      (count)
   );

   assign imem.imem_req  = req;
   assign imem.imem_addr = word_align(pc_q);
   assign valid_do       = valid;
   assign inst_do        = valid ? head.inst : NOP_INST;
   assign pc_do          = valid ? head.pc : ZERO_WORD;

endmodule

// File: tb/tb_stage_if.sv
// Self-checking bench for stage_if: directed vector table, randomized memory/stall/flush
// traffic against a fetch-order reference model, and an asynchronous mid-burst reset.
module tb_stage_if;
   import stage_if_pkg::*;

   localparam int DEPTH = 2;

   typedef struct {
      logic        gnt;
      logic        rv;
      logic        nop;
      logic        fl;
      logic [31:0] tgt;
      logic        req;
      logic [31:0] addr;
      logic        vld;
      logic [31:0] pc;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          rdy;
   } pend_t;

   logic        clk_i;
   logic        rst_i;
   logic        pipeline_flush_i;
   logic [31:0] redirect_pc_i;
   logic        pipeline_nop_i;
   logic        valid_do;
   logic [31:0] inst_do;
   logic [31:0] pc_do;

   stage_if_if imem ();

   stage_if #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .pipeline_flush_i (pipeline_flush_i),
      .redirect_pc_i    (redirect_pc_i),
      .pipeline_nop_i   (pipeline_nop_i),
      .imem             (imem),
      .valid_do         (valid_do),
      .inst_do          (inst_do),
      .pc_do            (pc_do)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int          checks;
   int          errors;
   int          cyc;
   int          consumed;
   vec_t        vecs[30];
   pend_t       pend[$];
   logic [31:0] fetch_pc, exp_pc, prev_pc, prev_inst, s_addr, s_pc, s_inst, r_tgt;
   logic        s_req, s_vld, r_gnt, r_nop, r_fl, r_rv;
   logic        flush_prev, hold_prev, req_hold_prev;

   // memory image: every address maps to a distinct instruction word
   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return (a * 32'd2654435761) ^ 32'h1357_9BDF;
   endfunction

   function automatic vec_t mk(input logic g, input logic rv, input logic nop, input logic fl,
                               input logic [31:0] tgt, input logic req, input logic [31:0] addr,
                               input logic vld, input logic [31:0] pc);
      vec_t v;
      v.gnt = g; v.rv = rv; v.nop = nop; v.fl = fl; v.tgt = tgt;
      v.req = req; v.addr = addr; v.vld = vld; v.pc = pc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_row(input int k);
      chk($sformatf("row%0d_req", k), imem.imem_req, vecs[k].req);
      chk($sformatf("row%0d_addr", k), imem.imem_addr, vecs[k].addr);
      chk($sformatf("row%0d_valid", k), valid_do, vecs[k].vld);
      chk($sformatf("row%0d_pc", k), pc_do, vecs[k].vld ? vecs[k].pc : 32'h0000_0000);
      chk($sformatf("row%0d_inst", k), inst_do, vecs[k].vld ? inst_of(vecs[k].pc) : 32'h0000_0013);
   endtask

   // called at a negedge: applies inputs for the next rising edge, models memory, advances
   task automatic drive_cycle(input logic g, input logic rv, input logic nop, input logic fl,
                              input logic [31:0] tgt, input int lat);
      logic  r;
      pend_t p;
      r                = imem.imem_req;
      imem.imem_gnt    = g;
      pipeline_nop_i   = nop;
      pipeline_flush_i = fl;
      redirect_pc_i    = tgt;
      if (rv && pend.size() > 0) begin
         imem.imem_rvalid = 1'b1;
         imem.imem_rdata  = inst_of(pend[0].addr);
         p = pend.pop_front();
      end else begin
         imem.imem_rvalid = 1'b0;
         imem.imem_rdata  = 32'h0000_0000;
      end
      if (r && g) pend.push_back('{addr: imem.imem_addr, rdy: cyc + 1 + lat});
      @(posedge clk_i);
      @(negedge clk_i);
      cyc++;
   endtask

   initial begin
      checks = 0; errors = 0; cyc = 0; consumed = 0;
      rst_i = 1'b0; pipeline_flush_i = 1'b0; pipeline_nop_i = 1'b0; redirect_pc_i = 32'h0;
      imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0; imem.imem_rdata = 32'h0;

      //              g     rv    nop   fl    tgt            req   addr           vld   pc
      vecs[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0000, 1'b0, 32'h0);
      vecs[1]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0000, 1'b0, 32'h0);
      vecs[2]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b0, 32'h0);
      vecs[3]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0008, 1'b1, 32'h0000_0000);
      vecs[4]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0008, 1'b1, 32'h0000_0004);
      vecs[5]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_000C, 1'b0, 32'h0);
      vecs[6]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0010, 1'b1, 32'h0000_0008);
      vecs[7]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0010, 1'b1, 32'h0000_000C);
      vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0014, 1'b0, 32'h0);
      vecs[9]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010);
      vecs[10] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010);
      vecs[11] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010);
      vecs[12] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010);
      vecs[13] = mk(1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010);
      vecs[14] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0018, 1'b1, 32'h0000_0010);
      vecs[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_0018, 1'b1, 32'h0000_0014);
      vecs[16] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_001C, 1'b0, 32'h0);
      vecs[17] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_0020, 1'b1, 32'h0000_0018);
      // flush coincides with the grant of 0x20 and the response for 0x1C
      vecs[18] = mk(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_2001, 1'b1, 32'h0000_0020, 1'b0, 32'h0);
      vecs[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_2000, 1'b0, 32'h0);
      vecs[20] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_2000, 1'b0, 32'h0);
      vecs[21] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_2004, 1'b0, 32'h0);
      // flush with two requests outstanding
      vecs[22] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1003, 1'b0, 32'h0000_2008, 1'b0, 32'h0);
      vecs[23] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_1000, 1'b0, 32'h0);
      vecs[24] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_1000, 1'b0, 32'h0);
      vecs[25] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_1000, 1'b0, 32'h0);
      vecs[26] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_1004, 1'b0, 32'h0);
      vecs[27] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0000_1008, 1'b1, 32'h0000_1000);
      vecs[28] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_1008, 1'b1, 32'h0000_1004);
      vecs[29] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_1008, 1'b0, 32'h0);

      repeat (3) @(negedge clk_i);
      chk("reset_req", imem.imem_req, 1'b0);
      chk("reset_addr", imem.imem_addr, 32'h0000_0000);
      chk("reset_valid", valid_do, 1'b0);
      chk("reset_inst", inst_do, 32'h0000_0013);
      chk("reset_pc", pc_do, 32'h0000_0000);
      rst_i = 1'b1;

      for (int k = 0; k < 30; k++) begin
         check_row(k);
         drive_cycle(vecs[k].gnt, vecs[k].rv, vecs[k].nop, vecs[k].fl, vecs[k].tgt, 0);
      end

      // randomized traffic against the fetch-order model
      fetch_pc = 32'h0000_1008; exp_pc = 32'h0000_1008;
      flush_prev = 1'b0; hold_prev = 1'b0; req_hold_prev = 1'b0;
      prev_pc = 32'h0; prev_inst = 32'h0;
      for (int n = 0; n < 4000; n++) begin
         s_req = imem.imem_req; s_addr = imem.imem_addr;
         s_vld = valid_do; s_pc = pc_do; s_inst = inst_do;
         if (flush_prev) begin
            chk("flush_bubble", s_vld, 1'b0);
         end else if (hold_prev) begin
            chk("stall_valid", s_vld, 1'b1);
            chk("stall_pc", s_pc, prev_pc);
            chk("stall_inst", s_inst, prev_inst);
         end
         if (req_hold_prev) chk("req_hold", s_req, 1'b1);
         if (s_req) begin
            chk("fetch_addr", s_addr, fetch_pc);
            chk("credit", pend.size() < DEPTH, 1'b1);
         end
         r_gnt = ($urandom_range(0, 1) == 0);
         r_nop = ($urandom_range(0, 3) == 0);
         r_fl  = ($urandom_range(0, 29) == 0);
         r_tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom);
         r_rv  = 1'b0;
         if (pend.size() > 0) r_rv = (pend[0].rdy <= cyc);
         if (s_vld && !r_nop && !r_fl) begin
            chk("present_pc", s_pc, exp_pc);
            chk("present_inst", s_inst, inst_of(exp_pc));
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (r_fl) begin
            fetch_pc = r_tgt & 32'hFFFF_FFFC;
            exp_pc   = fetch_pc;
         end else if (s_req && r_gnt) begin
            fetch_pc = fetch_pc + 32'd4;
         end
         hold_prev     = s_vld && r_nop && !r_fl;
         prev_pc       = s_pc;
         prev_inst     = s_inst;
         flush_prev    = r_fl;
         req_hold_prev = s_req && !r_gnt && !r_fl;
         drive_cycle(r_gnt, r_rv, r_nop, r_fl, r_tgt, int'($urandom_range(0, 4)));
      end
      chk("progress", consumed > 200, 1'b1);

      // fill the queue under stall, then pull reset asynchronously mid-cycle
      for (int n = 0; n < 6; n++) drive_cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 0);
      chk("burst_valid", valid_do, 1'b1);
      imem.imem_gnt = 1'b0; imem.imem_rvalid = 1'b0;
      @(posedge clk_i);
      #2 rst_i = 1'b0;
      #1;
      chk("async_rst_req", imem.imem_req, 1'b0);
      chk("async_rst_addr", imem.imem_addr, 32'h0000_0000);
      chk("async_rst_valid", valid_do, 1'b0);
      chk("async_rst_inst", inst_do, 32'h0000_0013);
      chk("async_rst_pc", pc_do, 32'h0000_0000);
      pend.delete();
      pipeline_nop_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         check_row(k);
         drive_cycle(vecs[k].gnt, vecs[k].rv, vecs[k].nop, vecs[k].fl, vecs[k].tgt, 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
